// File: rtl/axis_trig_scheduler.sv
// Multi-shot trigger sequencer: arm, wait for an external pulse, then fire delayed strobes aligned to sync.
// Latency: sync accepted in cycle t gives trig_out in cycle t+1+delay; all outputs are registered.
// Backpressure: none; sync outside WAIT_SYNC is dropped, arm is only honoured in IDLE, abort wins over all.
//
// Ports:
//   aclk, areset         clock, synchronous active-high reset
//   cfg_delay            cycles from accepted sync to trigger (latched at arm)
//   cfg_holdoff          cycles after a trigger during which sync is ignored (latched at arm)
//   cfg_count            shots per sequence, 0 = continuous (latched at arm)
//   arm, abort, pulse    start request, terminate, external start event
//   sync                 alignment reference
//   trig_out, done       one-cycle strobes
//   busy                 high whenever not idle
//   shot_cnt             triggers emitted in the current/last sequence
//
// Optional: define AXIS_TRIG_SCHED_SYNC_EDGE_EN to accept only rising edges of sync.

module axis_trig_scheduler #(
  parameter int CNTR_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [CNTR_WIDTH-1:0] cfg_delay,
  input  logic [CNTR_WIDTH-1:0] cfg_holdoff,
  input  logic [CNTR_WIDTH-1:0] cfg_count,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  pulse,
  input  logic                  sync,
  output logic                  trig_out,
  output logic                  busy,
  output logic                  done,
  output logic [CNTR_WIDTH-1:0] shot_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT_SYNC,
    S_DELAY,
    S_FIRE,
    S_HOLDOFF,
    S_DONE
  } state_t;

  localparam logic [CNTR_WIDTH-1:0] ONE = CNTR_WIDTH'(1);

  state_t                state;
  state_t                state_nxt;
  logic [CNTR_WIDTH-1:0] delay_q;
  logic [CNTR_WIDTH-1:0] holdoff_q;
  logic [CNTR_WIDTH-1:0] count_q;
  logic [CNTR_WIDTH-1:0] cnt;
  logic [CNTR_WIDTH-1:0] shot_inc;
  logic                  last_shot;
  logic                  sync_hit;

`ifdef AXIS_TRIG_SCHED_SYNC_EDGE_EN
  // Previous sample resets high so a sync already asserted at reset is not an edge.
  logic sync_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      sync_q <= 1'b1;
    end else begin
      sync_q <= sync;
    end
  end

  assign sync_hit = sync & ~sync_q;
`else
  assign sync_hit = sync;
`endif

  // Wraps naturally in continuous mode.
  assign shot_inc  = shot_cnt + ONE;
  assign last_shot = (count_q != '0) && (shot_inc == count_q);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (arm) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (pulse) state_nxt = S_WAIT_SYNC;
      end
      S_WAIT_SYNC: begin
        if (sync_hit) state_nxt = (delay_q == '0) ? S_FIRE : S_DELAY;
      end
      S_DELAY: begin
        if (cnt == ONE) state_nxt = S_FIRE;
      end
      S_FIRE: begin
        if (last_shot)              state_nxt = S_DONE;
        else if (holdoff_q != '0)   state_nxt = S_HOLDOFF;
        else                        state_nxt = S_WAIT_SYNC;
      end
      S_HOLDOFF: begin
        if (cnt == ONE) state_nxt = S_WAIT_SYNC;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
    // Abort outranks every other transition; arm in IDLE is unaffected.
    if (abort && (state != S_IDLE)) state_nxt = S_IDLE;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      delay_q   <= '0;
      holdoff_q <= '0;
      count_q   <= '0;
      cnt       <= '0;
      shot_cnt  <= '0;
      trig_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      trig_out <= (state_nxt == S_FIRE);
      busy     <= (state_nxt != S_IDLE);
      done     <= (state_nxt == S_DONE);

      if ((state == S_IDLE) && arm) begin
        delay_q   <= cfg_delay;
        holdoff_q <= cfg_holdoff;
        count_q   <= cfg_count;
        shot_cnt  <= '0;
      end

      // A strobe already on the output counts even if abort is sampled in the same cycle.
      if (state == S_FIRE) begin
        shot_cnt <= shot_inc;
      end

      // One shared down-counter serves DELAY and HOLDOFF; loaded on entry.
      if ((state_nxt == S_DELAY) && (state != S_DELAY)) begin
        cnt <= delay_q;
      end else if ((state_nxt == S_HOLDOFF) && (state != S_HOLDOFF)) begin
        cnt <= holdoff_q;
      end else if ((state == S_DELAY) || (state == S_HOLDOFF)) begin
        cnt <= cnt - ONE;
      end
    end
  end

endmodule

// File: tb/tb_axis_trig_scheduler.sv
module tb_axis_trig_scheduler;

  localparam int W = 32;

  logic         aclk = 1'b0;
  logic         areset;
  logic [W-1:0] cfg_delay;
  logic [W-1:0] cfg_holdoff;
  logic [W-1:0] cfg_count;
  logic         arm;
  logic         abort;
  logic         pulse;
  logic         sync;
  logic         trig_out;
  logic         busy;
  logic         done;
  logic [W-1:0] shot_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int trig_n   = 0;
  int done_n   = 0;
  int trig_cyc[$];

  axis_trig_scheduler #(.CNTR_WIDTH(W)) dut (
    .aclk        (aclk),
    .areset      (areset),
    .cfg_delay   (cfg_delay),
    .cfg_holdoff (cfg_holdoff),
    .cfg_count   (cfg_count),
    .arm         (arm),
    .abort       (abort),
    .pulse       (pulse),
    .sync        (sync),
    .trig_out    (trig_out),
    .busy        (busy),
    .done        (done),
    .shot_cnt    (shot_cnt)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge aclk) begin
    if (trig_out) begin
      trig_n = trig_n + 1;
      trig_cyc.push_back(cyc);
    end
    if (done) done_n = done_n + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_done(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      tick();
      if (done) begin
        at = cyc;
        break;
      end
    end
  endtask

  int s, p, at, tn0, dn0, q0;

  initial begin
    areset = 1'b1; arm = 1'b0; abort = 1'b0; pulse = 1'b0; sync = 1'b0;
    cfg_delay = '0; cfg_holdoff = '0; cfg_count = '0;
    ticks(2);
    areset = 1'b0;
    chk("rst_trig", trig_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_shot", shot_cnt, 0);

    // Single shot, delay 5.
    cfg_delay = 5; cfg_holdoff = 0; cfg_count = 1;
    tn0 = trig_n; dn0 = done_n;
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t1_busy_armed", busy, 1);
    ticks(8);
    pulse = 1'b1; tick(); pulse = 1'b0;
    ticks(8);
    s = cyc; sync = 1'b1; tick(); sync = 1'b0;
    wait_done(30, at);
    chk("t1_done_cyc", at, s + 7);
    chk("t1_trig_cyc", trig_cyc[trig_cyc.size() - 1], s + 6);
    tick();
    chk("t1_busy_after", busy, 0);
    chk("t1_shot", shot_cnt, 1);
    chk("t1_trig_n", trig_n - tn0, 1);
    chk("t1_done_n", done_n - dn0, 1);

    // Zero delay; arm and pulse in the same cycle leaves the block ARMED.
    cfg_delay = 0; cfg_holdoff = 0; cfg_count = 1;
    tn0 = trig_n;
    arm = 1'b1; pulse = 1'b1; tick(); arm = 1'b0; pulse = 1'b0;
    sync = 1'b1; ticks(4); sync = 1'b0;
    chk("t2_armed_no_trig", trig_n - tn0, 0);
    chk("t2_armed_busy", busy, 1);
    pulse = 1'b1; tick(); pulse = 1'b0;
    sync = 1'b1; tick(); sync = 1'b0;
    chk("t2_trig_t1", trig_out, 1);
    tick();
    chk("t2_done", done, 1);
    chk("t2_trig_low", trig_out, 0);
    tick();
    chk("t2_busy_after", busy, 0);

    // Multi-shot with hold-off; sync held high, cfg_delay and arm poked while busy.
    cfg_delay = 2; cfg_holdoff = 8; cfg_count = 3;
    dn0 = done_n; q0 = trig_cyc.size();
    arm = 1'b1; tick(); arm = 1'b0;
    cfg_delay = 7;
    p = cyc; pulse = 1'b1; sync = 1'b1; tick(); pulse = 1'b0;
    ticks(15);
    arm = 1'b1; tick(); arm = 1'b0;
    wait_done(100, at);
    chk("t3_done_cyc", at, p + 29);
    tick();
    sync = 1'b0;
    chk("t3_trig_n", trig_cyc.size() - q0, 3);
    chk("t3_trig0", trig_cyc[q0], p + 4);
    chk("t3_trig1", trig_cyc[q0 + 1], p + 16);
    chk("t3_trig2", trig_cyc[q0 + 2], p + 28);
    chk("t3_shot", shot_cnt, 3);
    chk("t3_done_n", done_n - dn0, 1);
    chk("t3_busy_after", busy, 0);

    // Continuous mode, abort during DELAY of the sixth shot.
    cfg_delay = 3; cfg_holdoff = 2; cfg_count = 0;
    tn0 = trig_n; dn0 = done_n;
    arm = 1'b1; tick(); arm = 1'b0;
    pulse = 1'b1; tick(); pulse = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sync = 1'b1; tick(); sync = 1'b0;
      ticks(15);
    end
    chk("t4_trig_n5", trig_n - tn0, 5);
    chk("t4_shot5", shot_cnt, 5);
    sync = 1'b1; tick(); sync = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_busy_abort", busy, 0);
    ticks(8);
    chk("t4_no_6th", trig_n - tn0, 5);
    chk("t4_no_done", done_n - dn0, 0);
    chk("t4_shot_hold", shot_cnt, 5);

    // Reset in DELAY, then sync without re-arm.
    cfg_delay = 10; cfg_holdoff = 0; cfg_count = 1;
    arm = 1'b1; tick(); arm = 1'b0;
    pulse = 1'b1; tick(); pulse = 1'b0;
    sync = 1'b1; tick(); sync = 1'b0;
    ticks(3);
    tn0 = trig_n;
    areset = 1'b1; tick(); areset = 1'b0;
    chk("t5_trig", trig_out, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_shot", shot_cnt, 0);
    sync = 1'b1; ticks(15); sync = 1'b0;
    chk("t5_no_trig", trig_n - tn0, 0);
    chk("t5_idle", busy, 0);

    // Arm and abort together in IDLE: arm wins.
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    chk("t6_arm_wins", busy, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t6_abort_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_trig_scheduler.md
Name: axis_trig_scheduler

Overview:
Multi-shot trigger sequencer for the acquisition front end. Arms on a software command and waits for an external pulse. It then emits trigger strobes aligned to a sync reference, each after a programmable delay, repeated a programmed number of times with a hold-off between shots. It drives downstream acquisition and DAC start inputs and reports busy/done/shot count to the status register bank.

Parameters:
CNTR_WIDTH, 32, width of delay, hold-off, count and shot counters.

Ports:
aclk  input  1  clock; all logic on rising edge.
areset  input  1  reset, synchronous, active-high.
cfg_delay  input  CNTR_WIDTH  cycles from accepted sync to trigger.
cfg_holdoff  input  CNTR_WIDTH  cycles after a trigger during which sync is ignored.
cfg_count  input  CNTR_WIDTH  shots per sequence; 0 = continuous until abort.
arm  input  1  start request, sampled in IDLE only.
abort  input  1  terminate sequence.
pulse  input  1  external start event.
sync  input  1  alignment reference (level-sampled unless optional feature enabled).
trig_out  output  1  one-cycle trigger strobe.
busy  output  1  high in any state except IDLE.
done  output  1  one-cycle strobe at normal sequence completion.
shot_cnt  output  CNTR_WIDTH  triggers emitted in current/last sequence.

Behaviour:
- Reset: state IDLE; trig_out=0, busy=0, done=0, shot_cnt=0; internal counters and latched config cleared.
- All outputs registered; trig_out = (state==FIRE), busy = (state!=IDLE), done = (state==DONE).
- States: IDLE, ARMED, WAIT_SYNC, DELAY, FIRE, HOLDOFF, DONE.
- IDLE: arm=1 -> latch cfg_delay/cfg_holdoff/cfg_count, shot_cnt<=0, go ARMED. cfg_* changes while busy have no effect.
- ARMED: pulse=1 -> WAIT_SYNC. A pulse in the arm cycle is ignored, because the state is still IDLE.
- WAIT_SYNC: sync=1 in cycle t -> trig_out high in cycle t+1+delay exactly.
  - delay==0: go to FIRE directly.
  - delay>0: load counter=delay, go DELAY; decrement each cycle; at counter==1 go FIRE.
- Sync during ARMED, DELAY, FIRE or HOLDOFF is ignored, not queued.
- FIRE (one cycle): shot_cnt<=shot_cnt+1. Next state:
  - DONE if count!=0 and shot_cnt+1==count;
  - else HOLDOFF if holdoff>0 (counter=holdoff, exit at counter==1, i.e. holdoff cycles);
  - else WAIT_SYNC.
- Subsequent shots need no new pulse.
- Continuous mode (count==0): shot_cnt wraps modulo 2^CNTR_WIDTH; never enters DONE.
- DONE (one cycle): done=1, then IDLE. shot_cnt holds its value until the next arm.
- abort=1 in any non-IDLE state -> IDLE next cycle. No done, shot_cnt holds.
  - abort outranks every other transition. If abort is sampled while in WAIT_SYNC/DELAY, FIRE is not entered.
  - A trig_out already high in the abort cycle completes.
- arm while busy: ignored. arm and abort together in IDLE: arm wins (abort is a no-op in IDLE).
- Reset mid-sequence: immediate return to reset values on the next edge; no trig_out or done generated.

Optional Feature:
AXIS_TRIG_SCHED_SYNC_EDGE_EN:
- Defined: sync goes through a one-stage register. Acceptance in WAIT_SYNC requires a rising edge (sync=1 and previous sample=0), so a sync held high yields one shot, not repeated shots. The previous-sample register resets to 1, so a sync already high at reset is not an edge. Latency from the sync rising-edge cycle is unchanged.
- Undefined: level-sampled as above. No extra register.

Test Plan:
- Single shot: delay=5, holdoff=0, count=1; arm; pulse at cycle 10; sync at cycle 20 -> trig_out high only at cycle 26, done at cycle 27, shot_cnt=1, busy low from cycle 28.
- Zero delay: delay=0, count=1; sync sampled at cycle t -> trig_out at t+1.
- Multi-shot with hold-off: delay=2, holdoff=8, count=3; sync held high continuously after pulse -> trig_out spaced 12 cycles apart (1 FIRE + 8 HOLDOFF + 1 WAIT_SYNC + 2 DELAY), 3 strobes, done once, shot_cnt=3. With AXIS_TRIG_SCHED_SYNC_EDGE_EN: exactly 1 strobe, then stays in WAIT_SYNC.
- Continuous + abort: count=0, sync every 16 cycles; after 5 triggers assert abort during DELAY -> no 6th trig_out, done never asserted, shot_cnt=5, busy low next cycle.
- Ignored inputs: arm with pulse in the same cycle -> stays ARMED. Sync during ARMED/HOLDOFF -> no trigger. cfg_delay changed while busy -> timing uses latched value. Second arm while busy -> ignored.
- Reset mid-DELAY: areset=1 for one cycle -> all outputs 0 next cycle; no trig_out even if sync follows without re-arm.
